// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Streams a program image from a byte-wide receive channel into an
// instruction memory. Image format (all fields little-endian):
//   4 bytes : word count N
//   4*N bytes : instruction words, written to BASE_ADDR + 4*i
//   1 byte  : XOR of every preceding length and data byte (checksum builds only)
//
// Build option:
//   LOADER_CHECKSUM_EN - when defined, adds the CSUM state and the running XOR.
//                        A matching checksum byte ends at DONE, a mismatch at ERR.
//                        When undefined, the load ends at DONE after the last
//                        write (or straight after the length when N == 0).
//
// Parameters:
//   ADDR_W    - width of the instruction-memory byte address
//   DEPTH     - largest word count accepted; larger counts abort the load
//   BASE_ADDR - byte address of word 0 (word-aligned)
//
// Ports:
//   clk, rst       - clock (rising edge) and asynchronous active-high reset
//   start          - one-cycle pulse; starts a load from IDLE, DONE or ERR
//   rx_data        - incoming byte
//   rx_valid       - rx_data is valid this cycle
//   rx_ready       - loader can take a byte this cycle
//   we, addr, dout - instruction-memory write port (we is a single-cycle pulse)
//   busy           - load in progress
//   done / err     - last load finished cleanly / aborted
//   word_count     - words written by the current or last load
//   dbg_state      - current FSM state encoding, for observation only
//
// Handshake: a byte moves on every rising clk edge where rx_valid and
// rx_ready are both high; the sender holds rx_data stable while rx_valid is
// high and rx_ready is low, and rx_ready never depends on rx_valid.
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       word_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CSUM  = 3'd6
`endif
  } state_t;

  localparam logic [31:0] DEPTH_W = DEPTH;

  // Where a load goes once all words (possibly zero) have been written.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_len;
  logic [31:0]       r_word;
  logic [31:0]       r_word_count;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_dout;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_rx_ready;
  logic              w_accept;
  logic              w_last_byte;
  logic              w_start_ok;
  logic [31:0]       w_len_full;
  logic [31:0]       w_word_full;
  logic [31:0]       w_wc_inc;
  logic [ADDR_W-1:0] w_addr_off;

  // ---------------------------------------------------------------------------
  // Handshake and byte assembly helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rx_ready = 1'b0;
    case (r_state)
      S_LEN, S_DATA: w_rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:        w_rx_ready = 1'b1;
`endif
      default:       w_rx_ready = 1'b0;
    endcase
  end

  assign w_accept    = rx_valid & w_rx_ready;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                (r_state == S_ERR));

  // The fourth byte is not yet in its register when the decision is made,
  // so both the length and the word are completed from rx_data directly.
  assign w_len_full  = {rx_data, r_len[23:0]};
  assign w_word_full = {rx_data, r_word[23:0]};
  assign w_wc_inc    = r_word_count + 32'd1;
  // 4*word_count in address width; overflow wraps modulo 2^ADDR_W.
  assign w_addr_off  = ADDR_W'(r_word_count) << 2;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_accept && w_last_byte) begin
          if (w_len_full > DEPTH_W)      w_state_nxt = S_ERR;
          else if (w_len_full == 32'd0)  w_state_nxt = S_END;
          else                           w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && w_last_byte) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        // word_count is bumped on this same edge, so compare the bumped value.
        if (w_wc_inc < r_len) w_state_nxt = S_DATA;
        else                  w_state_nxt = S_END;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          if (rx_data == r_csum) w_state_nxt = S_DONE;
          else                   w_state_nxt = S_ERR;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_idx   <= 2'd0;
      r_len        <= 32'd0;
      r_word       <= 32'd0;
      r_word_count <= 32'd0;
      r_addr       <= BASE_ADDR;
      r_dout       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      if (w_start_ok) begin
        r_byte_idx   <= 2'd0;
        r_len        <= 32'd0;
        r_word_count <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
        r_csum       <= 8'd0;
`endif
      end

      if (w_accept) begin
        // Index wraps 3 -> 0, so DATA always begins at byte 0 after LEN.
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_state == S_LEN) begin
          r_len[{r_byte_idx, 3'b000} +: 8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
          r_csum <= r_csum ^ rx_data;
`endif
        end
        if (r_state == S_DATA) begin
          r_word[{r_byte_idx, 3'b000} +: 8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
          r_csum <= r_csum ^ rx_data;
`endif
          // Present the write port for the WRITE cycle; it then holds.
          if (w_last_byte) begin
            r_addr <= BASE_ADDR + w_addr_off;
            r_dout <= w_word_full;
          end
        end
      end

      if (r_state == S_WRITE) begin
        r_word_count <= w_wc_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers so reset takes effect immediately.
  // ---------------------------------------------------------------------------
  assign rx_ready   = w_rx_ready;
  assign we         = (r_state == S_WRITE);
  assign addr       = r_addr;
  assign dout       = r_dout;
  assign busy       = w_rx_ready | (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign word_count = r_word_count;
  assign dbg_state  = r_state;

endmodule
